// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register and its helpers.
package usr_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 2'b00;
  localparam usr_mode_t MODE_SHR  = 2'b01;
  localparam usr_mode_t MODE_SHL  = 2'b10;
  localparam usr_mode_t MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/universal_shift_reg_frame_counter.sv
// Counts shifts within a frame of WIDTH bits and pulses done for one
// cycle after the WIDTH-th shift. The count wraps straight to zero, so
// back-to-back frames need no idle cycle.
module shift_frame_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  // Next count and frame-done pulse; a clear (load) takes priority over counting.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and pulse registers; reset aborts any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule : shift_frame_counter

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with clock enable and a frame counter that flags every
// WIDTH completed shifts. Serial outputs are taken straight from q.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             dout_r,
  output logic             dout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             shift_en;
  logic             load_en;

  // Mode mux: next register value plus the strobes that drive the frame counter.
  always_comb begin
    q_d      = q_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    if (en) begin
      case (usr_mode_t'(mode))
        MODE_SHR: begin
          q_d      = {din, q_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], din};
          shift_en = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = pin;
          load_en = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // Data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_frame_counter #(
    .WIDTH(WIDTH)
  ) u_frame_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (shift_en),
    .clr  (load_en),
    .cnt  (shift_cnt),
    .done (frame_done)
  );

  assign q      = q_q;
  assign dout_r = q_q[0];
  assign dout_l = q_q[WIDTH-1];

endmodule : universal_shift_reg

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register and the successor to the fixed 4-stage serial-in/serial-out chain. It adds configurable width and four modes: hold, shift right, shift left and parallel load. It also has a clock enable, parallel output, and a shift counter that pulses a frame-done flag after WIDTH shifts. It is used as the serialiser/deserialiser front-end of serial-link blocks.

Parameters:
- WIDTH, 8, register length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; when 0 the block holds all state
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- din  in  1  serial input bit
- pin  in  WIDTH  parallel load data
- q  out  WIDTH  register contents, registered
- dout_r  out  1  right-shift serial output, equal to q[0]
- dout_l  out  1  left-shift serial output, equal to q[WIDTH-1]
- shift_cnt  out  CNT_W  number of shifts since the last load, reset or frame wrap
- frame_done  out  1  one-cycle registered pulse after the WIDTH-th shift

Behaviour:
- Reset:
  - rst=1 forces q=0, shift_cnt=0 and frame_done=0 immediately, independent of clk.
  - Release is synchronous to the next rising edge; the first active edge after release behaves normally.
- dout_r and dout_l are pure wires from q, so they add no latency.
- On each rising edge with rst=0:
  - en=0: q and shift_cnt hold; frame_done is driven 0.
  - en=1, mode=00 (hold): q and shift_cnt hold; frame_done=0.
  - en=1, mode=01 (shift right): q <= {din, q[WIDTH-1:1]}. The bit leaving the register is the pre-edge q[0], seen on dout_r before the edge.
  - en=1, mode=10 (shift left): q <= {q[WIDTH-2:0], din}. The bit leaving is the pre-edge q[WIDTH-1].
  - en=1, mode=11 (load): q <= pin; shift_cnt <= 0; frame_done=0.
- Shift counter (modes 01 and 10 only; both directions count):
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and frame_done <= 1 on the same edge.
  - Otherwise: shift_cnt <= shift_cnt+1 and frame_done <= 0.
  - frame_done is therefore high for exactly the cycle following the WIDTH-th shift.
  - shift_cnt never equals WIDTH on the output; it wraps from WIDTH-1 to 0.
- Direction changes mid-frame are legal. The counter keeps counting total shifts and does not restart.
- Back-to-back frames: continuous shifting gives a frame_done pulse every WIDTH enabled shift cycles with no gap cycle.
- A load on the cycle after the wrap clears frame_done on the following edge, as normal.
- Cycles with en=0 or mode=00 in the middle of a frame stretch the frame and do not reset the count.
- Reset asserted mid-frame aborts the frame. No frame_done is produced for partial data.
- Every assignment is fully defined each cycle. There are no latches and no X propagation from din or pin when they are unused.

Decomposition:
- Shared package usr_pkg:
  - mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - typedef usr_mode_t (2-bit)
- One natural sub-module, shift_frame_counter:
  - parameter WIDTH; inputs clk, rst, inc, clr; outputs cnt, done.
  - It owns the wrap logic and the frame_done register.
  - The top level owns the data register and the mode mux.

Test Plan (WIDTH=4 unless noted):
1. Async reset:
   - Preload q=4'b1111, then assert rst mid-cycle with no clk edge -> q=0000, shift_cnt=0, frame_done=0 immediately.
   - First edge after release with mode=11, pin=4'b1010 -> q=1010.
2. Load then shift right:
   - Load 4'b1011, then 4 cycles of mode=01, din=0 -> dout_r before each edge reads 1,1,0,1.
   - q ends at 0000; shift_cnt reads 1,2,3,0; frame_done=1 only in the cycle after the 4th shift.
3. Shift left from zero:
   - din sequence 1,0,1,1 with mode=10 -> q ends at 1011 and frame_done pulses once.
   - dout_l goes 0 → 0 → 0 → 1 (q=0001, 0010, 0101, 1011; q[3] first becomes 1 after the 4th shift).
4. Enable/hold gaps:
   - Shift right 2 bits, then 3 cycles of en=0, then 1 cycle of mode=00 -> q and shift_cnt=2 unchanged, frame_done stays 0.
   - 2 more shifts -> frame_done pulses.
5. Load mid-frame:
   - 3 shifts, then load pin=4'b0110 -> shift_cnt=0, no frame_done, q=0110.
   - Continuous shifting for 8 cycles -> exactly 2 frame_done pulses, 4 cycles apart.
6. WIDTH=32 regression:
   - Load 32'hDEADBEEF, then 32 right shifts with din=0 -> dout_r streams 0xDEADBEEF LSB first.
   - q=0 at the end and a single frame_done pulse.
